// File: rtl/lc3_reg_file.sv
// lc3_reg_file: eight-entry, 16-bit LC-3 general-purpose register file.
// It generates the NZP condition codes from write-back data and keeps a
// one-bit-per-register busy scoreboard. Decode uses the combinational STALL
// to hold while a source register still has a write pending.
//
// Handshake: there is no valid/ready pair. WR_EN and RSV_EN are single-cycle
// strobes sampled on the rising edge of CLK, and each is always accepted.
// STALL is advisory to decode: it is asserted while a selected source is busy
// and does not back-pressure either strobe.
module lc3_reg_file #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [2:0]       WR_SEL,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             LD_CC,
  input  logic             RSV_EN,
  input  logic [2:0]       RSV_SEL,
  input  logic [2:0]       SR1_SEL,
  input  logic [2:0]       SR2_SEL,
  input  logic             SR2_USED,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic             CC_N,
  output logic             CC_Z,
  output logic             CC_P,
  output logic [NREG-1:0]  BUSY,
  output logic             STALL,
  output logic             RSV_ERR
);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_neg;
  logic             wr_zero;
  logic [NREG-1:0]  busy_next;
  logic             rsv_err_next;

  // Register storage. Reads are not bypassed, so a value written on an edge
  // becomes visible only after that edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WR_EN) begin
      regs[WR_SEL] <= WR_DATA;
    end
  end

  // Sign and zero detection on the write-back data feed the NZP codes.
  always_comb begin
    wr_neg  = WR_DATA[WIDTH-1];
    wr_zero = (WR_DATA == '0);
  end

  // Condition codes follow a qualified write. They reset to Z, so exactly one
  // of N, Z and P is set at all times.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CC_N <= 1'b0;
      CC_Z <= 1'b1;
      CC_P <= 1'b0;
    end else if (WR_EN && LD_CC) begin
      CC_N <= wr_neg;
      CC_Z <= wr_zero;
      CC_P <= ~wr_neg & ~wr_zero;
    end
  end

  // Next scoreboard value. A write clears its bit, then a reserve sets its
  // bit. The reserve is applied last so that it wins when both name the same
  // register, which leaves a new pending write.
  always_comb begin
    busy_next = BUSY;
    if (WR_EN)  busy_next[WR_SEL]  = 1'b0;
    if (RSV_EN) busy_next[RSV_SEL] = 1'b1;
  end

  // A double reservation is a reserve on a busy register with no same-edge
  // write to that register. The one-bit scoreboard loses the extra reserve,
  // so it is flagged instead.
  always_comb begin
    rsv_err_next = RSV_EN && BUSY[RSV_SEL] && !(WR_EN && (WR_SEL == RSV_SEL));
  end

  // Scoreboard and error-pulse registers. RSV_ERR is recomputed on every edge,
  // so each offence gives one pulse and back-to-back offences give
  // consecutive pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUSY    <= '0;
      RSV_ERR <= 1'b0;
    end else begin
      BUSY    <= busy_next;
      RSV_ERR <= rsv_err_next;
    end
  end

  // Stall decode while any operand it uses is still awaiting write-back.
  // There is no forwarding, so a same-cycle WR_EN does not clear the stall.
  always_comb begin
    STALL = BUSY[SR1_SEL] | (SR2_USED & BUSY[SR2_SEL]);
  end

  // Register contents drive the operand mux inputs D_IN0..D_IN7.
  always_comb begin
    R0 = regs[0];
    R1 = regs[1];
    R2 = regs[2];
    R3 = regs[3];
    R4 = regs[4];
    R5 = regs[5];
    R6 = regs[6];
    R7 = regs[7];
  end

endmodule
